// File: rtl/bab_sweep_ctrl_if.sv
// Start/done handshake between the sweep controller and the bab_2_3_5 datapath.
interface bab_sweep_ctrl_if #(
    parameter int N_W   = 6,
    parameter int VAL_W = 13
);
    logic             dp_clear;
    logic             dp_start;
    logic [N_W-1:0]   dp_n;
    logic             dp_ready;
    logic             dp_done;
    logic [VAL_W-1:0] dp_val;

    modport master (
        output dp_clear, dp_start, dp_n,
        input  dp_ready, dp_done, dp_val
    );

    modport slave (
        input  dp_clear, dp_start, dp_n,
        output dp_ready, dp_done, dp_val
    );
endinterface

// File: rtl/bab_sweep_ctrl.sv
// Sweeps n from 0 to a programmable last value, launching one datapath run per n
// and holding each result on the display for DWELL cycles.
module bab_sweep_ctrl #(
    parameter int N_W     = 6,
    parameter int VAL_W   = 13,
    parameter int DISP_W  = 14,
    parameter int DWELL   = 100_000_000,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_loop,
    input  logic [N_W-1:0]    i_n_last,
    bab_sweep_ctrl_if.master  dp,
    output logic [DISP_W-1:0] o_disp_val,
    output logic              o_greeting,
    output logic              o_busy,
    output logic              o_err
);
    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_LAUNCH, S_WAIT, S_DWELL, S_DONE, S_ERR
    } state_t;

    localparam int DW_CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int TO_CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [DW_CW-1:0]  DWELL_LAST = DW_CW'(DWELL - 1);
    localparam logic [TO_CW-1:0]  TO_LAST    = TO_CW'(TIMEOUT - 1);
    localparam logic [DISP_W-1:0] ERR_CODE   = DISP_W'(9999);

    state_t             state_q, state_d;
    logic [N_W-1:0]     n_q, n_d;
    logic [N_W-1:0]     n_last_q, n_last_d;
    logic [DW_CW-1:0]   dwell_cnt_q, dwell_cnt_d;
    logic [TO_CW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [DISP_W-1:0]  disp_val_q, disp_val_d;
    logic               greeting_q, greeting_d;
    logic               dp_clear_q, dp_clear_d;
    logic               dp_start_q, dp_start_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic               in_sweep;

    assign in_sweep = (state_q == S_CLR) || (state_q == S_LAUNCH) ||
                      (state_q == S_WAIT) || (state_q == S_DWELL);

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can leave one unassigned and infer a latch.
        state_d     = state_q;
        n_d         = n_q;
        n_last_d    = n_last_q;
        dwell_cnt_d = dwell_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        disp_val_d  = disp_val_q;
        greeting_d  = greeting_q;
        err_d       = err_q;
        dp_clear_d  = 1'b0;
        dp_start_d  = 1'b0;

        // Stop outranks done and the dwell terminal count; the clear pulse lands on the first IDLE cycle.
        if (in_sweep && i_stop) begin
            state_d    = S_IDLE;
            dp_clear_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (i_start) begin
                        n_last_d   = i_n_last;
                        n_d        = '0;
                        err_d      = 1'b0;
                        dp_clear_d = 1'b1;
                        state_d    = S_CLR;
                    end
                end
                S_CLR: state_d = S_LAUNCH;
                S_LAUNCH: begin
                    if (dp.dp_ready) begin
                        dp_start_d = 1'b1;
                        tmo_cnt_d  = '0;
                        state_d    = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (dp.dp_done) begin
                        disp_val_d  = DISP_W'(dp.dp_val);
                        greeting_d  = 1'b0;
                        dwell_cnt_d = '0;
                        state_d     = S_DWELL;
                    end else if (tmo_cnt_q == TO_LAST) begin
                        err_d      = 1'b1;
                        disp_val_d = ERR_CODE;
                        state_d    = S_ERR;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + TO_CW'(1);
                    end
                end
                S_DWELL: begin
                    if (dwell_cnt_q == DWELL_LAST) begin
                        // A loop restart goes straight back to LAUNCH without clearing the datapath.
                        if (n_q < n_last_q) begin
                            n_d     = n_q + N_W'(1);
                            state_d = S_LAUNCH;
                        end else if (i_loop) begin
                            n_d     = '0;
                            state_d = S_LAUNCH;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        dwell_cnt_d = dwell_cnt_q + DW_CW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d == S_CLR) || (state_d == S_LAUNCH) ||
                 (state_d == S_WAIT) || (state_d == S_DWELL);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            n_last_q    <= '0;
            dwell_cnt_q <= '0;
            tmo_cnt_q   <= '0;
            disp_val_q  <= '0;
            greeting_q  <= 1'b1;
            dp_clear_q  <= 1'b0;
            dp_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            n_last_q    <= n_last_d;
            dwell_cnt_q <= dwell_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            disp_val_q  <= disp_val_d;
            greeting_q  <= greeting_d;
            dp_clear_q  <= dp_clear_d;
            dp_start_q  <= dp_start_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign dp.dp_clear = dp_clear_q;
    assign dp.dp_start = dp_start_q;
    assign dp.dp_n     = n_q;
    assign o_disp_val  = disp_val_q;
    assign o_greeting  = greeting_q;
    assign o_busy      = busy_q;
    assign o_err       = err_q;
endmodule

// File: tb/tb_bab_sweep_ctrl.sv
// Bench for bab_sweep_ctrl with a datapath model that answers 10*n three cycles after each start.
module tb_bab_sweep_ctrl;
    localparam int N_W     = 6;
    localparam int VAL_W   = 13;
    localparam int DISP_W  = 14;
    localparam int DWELL   = 4;
    localparam int TIMEOUT = 16;
    localparam int PERIOD  = 9;   // 4 WAIT cycles + DWELL + 1 LAUNCH cycle

    logic              i_clk    = 1'b0;
    logic              i_rst_n  = 1'b1;
    logic              i_start  = 1'b0;
    logic              i_stop   = 1'b0;
    logic              i_loop   = 1'b0;
    logic [N_W-1:0]    i_n_last = '0;
    logic [DISP_W-1:0] o_disp_val;
    logic              o_greeting;
    logic              o_busy;
    logic              o_err;

    bab_sweep_ctrl_if #(.N_W(N_W), .VAL_W(VAL_W)) dp_if ();

    bab_sweep_ctrl #(
        .N_W(N_W), .VAL_W(VAL_W), .DISP_W(DISP_W), .DWELL(DWELL), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (i_start),
        .i_stop     (i_stop),
        .i_loop     (i_loop),
        .i_n_last   (i_n_last),
        .dp         (dp_if),
        .o_disp_val (o_disp_val),
        .o_greeting (o_greeting),
        .o_busy     (o_busy),
        .o_err      (o_err)
    );

    always #5 i_clk = ~i_clk;

    logic ready_en = 1'b1;
    logic mute     = 1'b0;
    assign dp_if.dp_ready = ready_en;

    int          checks        = 0;
    int          failures      = 0;
    int          cyc           = 0;
    int          pend          = 0;
    logic [N_W-1:0] pend_n     = '0;
    int          clr_total     = 0;
    int          start_total   = 0;
    int          overlap_total = 0;
    int          start_n[$];
    int          start_cyc[$];

    // Datapath model and pulse monitor, evaluated on the falling edge.
    always @(negedge i_clk) begin
        cyc++;
        dp_if.dp_done = 1'b0;
        dp_if.dp_val  = '0;
        if (dp_if.dp_clear) clr_total++;
        if (dp_if.dp_start && dp_if.dp_clear) overlap_total++;
        if (dp_if.dp_start) begin
            start_total++;
            start_n.push_back(int'(dp_if.dp_n));
            start_cyc.push_back(cyc);
        end
        if (!i_rst_n || dp_if.dp_clear) begin
            pend = 0;
        end else if (dp_if.dp_start) begin
            pend   = mute ? 0 : 3;
            pend_n = dp_if.dp_n;
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                dp_if.dp_done = 1'b1;
                dp_if.dp_val  = VAL_W'(10 * int'(pend_n));
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
        #1;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 400 && o_busy; i++) tick();
        check({name, "_idle"}, int'(o_busy), 0);
    endtask

    task automatic wait_starts(input string name, input int k);
        for (int i = 0; i < 400 && start_total < k; i++) tick();
        check({name, "_starts_reached"}, (start_total >= k) ? 1 : 0, 1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_disp"},     int'(o_disp_val), 0);
        check({name, "_greeting"}, int'(o_greeting), 1);
        check({name, "_dp_n"},     int'(dp_if.dp_n), 0);
        check({name, "_dp_start"}, int'(dp_if.dp_start), 0);
        check({name, "_dp_clear"}, int'(dp_if.dp_clear), 0);
        check({name, "_busy"},     int'(o_busy), 0);
        check({name, "_err"},      int'(o_err), 0);
    endtask

    typedef struct {
        logic [N_W-1:0] n_last;
        int             exp_starts;
        int             exp_disp;
    } vec_t;

    vec_t vecs[3];
    int   sb;
    int   cb;

    initial begin
        vecs[0] = '{n_last: 6'd0, exp_starts: 1, exp_disp: 0};
        vecs[1] = '{n_last: 6'd2, exp_starts: 3, exp_disp: 20};
        vecs[2] = '{n_last: 6'd5, exp_starts: 6, exp_disp: 50};

        #2 i_rst_n = 1'b0;
        repeat (2) tick();
        check_reset_outputs("por");
        i_rst_n = 1'b1;
        tick();

        // Plain sweeps with i_loop = 0.
        for (int v = 0; v < 3; v++) begin
            sb = start_total;
            cb = clr_total;
            i_n_last = vecs[v].n_last;
            i_loop   = 1'b0;
            pulse_start();
            wait_idle($sformatf("sweep%0d", v));
            check($sformatf("sweep%0d_starts", v), start_total - sb, vecs[v].exp_starts);
            check($sformatf("sweep%0d_clears", v), clr_total - cb, 1);
            check($sformatf("sweep%0d_disp", v), int'(o_disp_val), vecs[v].exp_disp);
            check($sformatf("sweep%0d_greeting", v), int'(o_greeting), 0);
            check($sformatf("sweep%0d_err", v), int'(o_err), 0);
            for (int k = 0; k < vecs[v].exp_starts; k++)
                check($sformatf("sweep%0d_n%0d", v, k), start_n[sb + k], k);
            for (int k = 1; k < vecs[v].exp_starts; k++)
                check($sformatf("sweep%0d_period%0d", v, k),
                      start_cyc[sb + k] - start_cyc[sb + k - 1], PERIOD);
        end

        // Looping sweep, then stop while waiting on the datapath.
        sb = start_total;
        cb = clr_total;
        i_n_last = 6'd1;
        i_loop   = 1'b1;
        pulse_start();
        wait_starts("loop", sb + 5);
        for (int k = 0; k < 5; k++)
            check($sformatf("loop_n%0d", k), start_n[sb + k], k % 2);
        check("loop_wrap_period", start_cyc[sb + 2] - start_cyc[sb + 1], PERIOD);
        check("loop_clears", clr_total - cb, 1);
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        check("stop_wait_busy", int'(o_busy), 0);
        check("stop_wait_clear", int'(dp_if.dp_clear), 1);
        check("stop_wait_disp", int'(o_disp_val), 10);
        tick();
        check("stop_wait_clear_end", int'(dp_if.dp_clear), 0);
        check("stop_wait_clears", clr_total - cb, 2);
        i_loop = 1'b0;

        // Datapath not ready for 50 cycles.
        sb = start_total;
        ready_en = 1'b0;
        i_n_last = 6'd1;
        pulse_start();
        repeat (50) tick();
        check("notready_starts", start_total - sb, 0);
        check("notready_err", int'(o_err), 0);
        check("notready_busy", int'(o_busy), 1);
        check("notready_dp_n", int'(dp_if.dp_n), 0);
        ready_en = 1'b1;
        tick();
        check("ready_start", int'(dp_if.dp_start), 1);
        check("ready_dp_n", int'(dp_if.dp_n), 0);
        wait_idle("ready");
        check("ready_disp", int'(o_disp_val), 10);
        check("ready_starts", start_total - sb, 2);

        // Start pulse during DWELL is ignored.
        sb = start_total;
        cb = clr_total;
        i_n_last = 6'd2;
        pulse_start();
        wait_starts("dwstart", sb + 1);
        repeat (4) tick();
        i_n_last = 6'd5;
        pulse_start();
        i_n_last = 6'd2;
        wait_idle("dwstart");
        check("dwstart_starts", start_total - sb, 3);
        check("dwstart_clears", clr_total - cb, 1);
        check("dwstart_disp", int'(o_disp_val), 20);
        check("dwstart_last_n", start_n[sb + 2], 2);

        // Stop and done in the same cycle.
        sb = start_total;
        pulse_start();
        wait_starts("stopdone", sb + 1);
        repeat (3) tick();
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        check("stopdone_busy", int'(o_busy), 0);
        check("stopdone_clear", int'(dp_if.dp_clear), 1);
        check("stopdone_disp", int'(o_disp_val), 20);
        repeat (20) tick();
        check("stopdone_starts", start_total - sb, 1);
        check("stopdone_disp_hold", int'(o_disp_val), 20);

        // Datapath never answers: timeout into ERR.
        sb = start_total;
        mute = 1'b1;
        i_n_last = 6'd3;
        pulse_start();
        wait_starts("tmo", sb + 1);
        for (int i = 0; i < 100 && !o_err; i++) tick();
        check("tmo_wait_cycles", cyc - start_cyc[sb], TIMEOUT);
        check("tmo_err", int'(o_err), 1);
        check("tmo_disp", int'(o_disp_val), 9999);
        check("tmo_busy", int'(o_busy), 0);
        repeat (5) tick();
        check("tmo_err_hold", int'(o_err), 1);
        check("tmo_disp_hold", int'(o_disp_val), 9999);
        check("tmo_no_relaunch", start_total - sb, 1);

        // Restart from ERR with start and stop together: start wins when not busy.
        mute = 1'b0;
        sb = start_total;
        i_n_last = 6'd0;
        i_start = 1'b1;
        i_stop  = 1'b1;
        tick();
        i_start = 1'b0;
        i_stop  = 1'b0;
        check("restart_err", int'(o_err), 0);
        check("restart_busy", int'(o_busy), 1);
        check("restart_clear", int'(dp_if.dp_clear), 1);
        check("restart_dp_n", int'(dp_if.dp_n), 0);
        wait_idle("restart");
        check("restart_disp", int'(o_disp_val), 0);
        check("restart_starts", start_total - sb, 1);
        check("restart_n", start_n[sb], 0);

        // Reset asserted mid-DWELL.
        sb = start_total;
        i_n_last = 6'd3;
        pulse_start();
        wait_starts("midrst", sb + 3);
        repeat (4) tick();
        check("midrst_pre_disp", int'(o_disp_val), 20);
        check("midrst_pre_busy", int'(o_busy), 1);
        i_rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tick();
        i_rst_n = 1'b1;
        tick();

        check("no_start_clear_overlap", overlap_total, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
